// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic {IDLE, OWNED} arb_state_t;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    // Sized for the largest supported arbiter (4 masters); callers zero-pad.
    function automatic logic [1:0] onehot2idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first requester strictly after
// the one-hot last owner, wrapping around.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);

    logic [N-1:0] mask_hi;
    logic [N-1:0] req_hi;
    logic [N-1:0] src;

    always_comb begin
        // Bits strictly above the last owner; empty when the owner is the top bit.
        mask_hi = ~((last << 1) - N'(1));
        req_hi  = req & mask_hi;
        src     = (|req_hi) ? req_hi : req;
        gnt     = src & (~src + N'(1));
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, with LOCK support
// and a strobe watchdog that terminates stalled accesses with ERR.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int AW        = WB_AW,
    parameter int DW        = WB_DW,
    parameter int TIMEOUT   = 64
) (
    input  logic                     p_clk,
    input  logic                     p_resetn,
    input  logic [N_MASTERS-1:0]     m_CYC_I,
    input  logic [N_MASTERS-1:0]     m_STB_I,
    input  logic [N_MASTERS-1:0]     m_WE_I,
    input  logic [N_MASTERS-1:0]     m_LOCK_I,
    input  logic [N_MASTERS*AW-1:0]  m_ADR_I,
    input  logic [N_MASTERS*DW-1:0]  m_DAT_I,
    input  logic [N_MASTERS*DW/8-1:0] m_SEL_I,
    output logic [DW-1:0]            m_DAT_O,
    output logic [N_MASTERS-1:0]     m_ACK_O,
    output logic [N_MASTERS-1:0]     m_ERR_O,
    output logic [N_MASTERS-1:0]     m_RTY_O,
    output logic                     s_CYC_O,
    output logic                     s_STB_O,
    output logic                     s_WE_O,
    output logic                     s_LOCK_O,
    output logic [AW-1:0]            s_ADR_O,
    output logic [DW-1:0]            s_DAT_O,
    output logic [DW/8-1:0]          s_SEL_O,
    input  logic [DW-1:0]            s_DAT_I,
    input  logic                     s_ACK_I,
    input  logic                     s_ERR_I,
    input  logic                     s_RTY_I,
    output logic [N_MASTERS-1:0]     grant
);

    localparam int SW  = DW / 8;
    localparam int IW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [N_MASTERS-1:0] LAST_RST = {1'b1, {(N_MASTERS-1){1'b0}}};

    arb_state_t             state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [N_MASTERS-1:0]   last_q, last_d;
    logic [N_MASTERS-1:0]   pick;
    logic [WDW-1:0]         wd_q, wd_d;
    logic                   wd_fire;

    logic [N_MASTERS-1:0][AW-1:0] adr_a;
    logic [N_MASTERS-1:0][DW-1:0] dat_a;
    logic [N_MASTERS-1:0][SW-1:0] sel_a;

    logic [3:0]    gnt_pad;
    logic [IW-1:0] owner;
    logic          owned;
    logic          own_cyc, own_stb, own_we, own_lock;
    logic          s_term, waiting;

    assign adr_a = m_ADR_I;
    assign dat_a = m_DAT_I;
    assign sel_a = m_SEL_I;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req  (m_CYC_I),
        .last (last_q),
        .gnt  (pick)
    );

    always_comb begin
        gnt_pad                = '0;
        gnt_pad[N_MASTERS-1:0] = grant_q;
        owner                  = IW'(onehot2idx(gnt_pad));
        owned                  = (state_q == OWNED);
        own_cyc                = |(m_CYC_I  & grant_q);
        own_stb                = |(m_STB_I  & grant_q);
        own_we                 = |(m_WE_I   & grant_q);
        own_lock               = |(m_LOCK_I & grant_q);
        s_term                 = s_ACK_I | s_ERR_I | s_RTY_I;
        waiting                = own_cyc & own_stb & ~s_term;
    end

    // A slave termination in the timeout cycle clears 'waiting', so the slave wins.
    if (TIMEOUT > 0) begin : g_wd
        always_comb begin
            wd_fire = waiting && (wd_q == WDW'(TIMEOUT - 1));
            wd_d    = (waiting && !wd_fire) ? wd_q + WDW'(1) : '0;
        end
    end else begin : g_no_wd
        always_comb begin
            wd_fire = 1'b0;
            wd_d    = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|m_CYC_I) begin
                    grant_d = pick;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                // CYC low under LOCK keeps the bus for the locked sequence.
                if (!own_cyc && !own_lock) begin
                    grant_d = '0;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        s_CYC_O  = own_cyc;
        s_STB_O  = own_cyc & own_stb & ~wd_fire;
        s_WE_O   = own_we;
        s_LOCK_O = own_lock;
        s_ADR_O  = owned ? adr_a[owner] : '0;
        s_DAT_O  = owned ? dat_a[owner] : '0;
        s_SEL_O  = owned ? sel_a[owner] : '0;
        m_DAT_O  = s_DAT_I;
        m_ACK_O  = grant_q & {N_MASTERS{s_ACK_I}};
        m_ERR_O  = grant_q & {N_MASTERS{s_ERR_I | wd_fire}};
        m_RTY_O  = grant_q & {N_MASTERS{s_RTY_I}};
        grant    = grant_q;
    end

    always_ff @(posedge p_clk) begin
        if (p_resetn) assert ($onehot0(grant_q));
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, TIMEOUT=8).
module tb_wb_rr_arbiter;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic [1:0]  m_CYC_I = '0, m_STB_I = '0, m_WE_I = '0, m_LOCK_I = '0;
    logic [63:0] m_ADR_I = '0, m_DAT_I = '0;
    logic [7:0]  m_SEL_I = 8'hff;
    logic [31:0] m_DAT_O;
    logic [1:0]  m_ACK_O, m_ERR_O, m_RTY_O, grant;
    logic        s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O;
    logic [31:0] s_ADR_O, s_DAT_O;
    logic [3:0]  s_SEL_O;
    logic [31:0] s_DAT_I = '0;
    logic        s_ACK_I = 1'b0, s_ERR_I = 1'b0, s_RTY_I = 1'b0;

    logic [31:0] slave_reg = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    wb_rr_arbiter #(.N_MASTERS(2), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .p_clk(p_clk), .p_resetn(p_resetn),
        .m_CYC_I(m_CYC_I), .m_STB_I(m_STB_I), .m_WE_I(m_WE_I), .m_LOCK_I(m_LOCK_I),
        .m_ADR_I(m_ADR_I), .m_DAT_I(m_DAT_I), .m_SEL_I(m_SEL_I),
        .m_DAT_O(m_DAT_O), .m_ACK_O(m_ACK_O), .m_ERR_O(m_ERR_O), .m_RTY_O(m_RTY_O),
        .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_LOCK_O(s_LOCK_O),
        .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_SEL_O(s_SEL_O),
        .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I), .s_ERR_I(s_ERR_I), .s_RTY_I(s_RTY_I),
        .grant(grant)
    );

    always #5 p_clk = ~p_clk;

    // Minimal slave register: captures write data on an acknowledged write.
    always @(posedge p_clk)
        if (s_CYC_O && s_STB_O && s_WE_O && s_ACK_I) slave_reg <= s_DAT_O;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge p_clk);
        #1;
    endtask

    initial begin
        // 1 reset
        m_ADR_I = {32'h0000_2000, 32'h0000_1000};
        m_DAT_I = {32'h2222_2222, 32'h1111_1111};
        m_CYC_I = 2'b01; m_STB_I = 2'b01; m_WE_I = 2'b01;
        repeat (2) cyc();
        s_ACK_I = 1'b1;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_scyc", s_CYC_O, 1'b0);
        chk("rst_ack", m_ACK_O, 2'b00);
        s_ACK_I = 1'b0;
        p_resetn = 1'b1;
        cyc();
        chk("rel_grant", grant, 2'b01);
        chk("rel_sstb", s_STB_O, 1'b1);
        chk("rel_sadr", s_ADR_O, 32'h0000_1000);
        s_ACK_I = 1'b1;
        #1;
        chk("rel_ack", m_ACK_O, 2'b01);
        cyc();
        s_ACK_I = 1'b0; m_CYC_I = 2'b00; m_STB_I = 2'b00;
        cyc();
        chk("rel_idle", grant, 2'b00);

        // 2 fairness (fresh reset so master 0 wins first)
        p_resetn = 1'b0;
        #1;
        p_resetn = 1'b1;
        m_DAT_I = {32'hA5A5_0002, 32'hA5A5_0001};
        m_CYC_I = 2'b11; m_STB_I = 2'b11; m_WE_I = 2'b11;
        cyc();
        for (int k = 0; k < 4; k++) begin
            logic [1:0] eg;
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            chk("fair_grant", grant, eg);
            chk("fair_sdat", s_DAT_O, (k % 2 == 1) ? 32'hA5A5_0002 : 32'hA5A5_0001);
            s_ACK_I = 1'b1;
            #1;
            chk("fair_ack", m_ACK_O, eg);
            cyc();
            s_ACK_I = 1'b0; m_CYC_I = ~eg; m_STB_I = ~eg;
            cyc();
            chk("fair_idle", grant, 2'b00);
            m_CYC_I = 2'b11; m_STB_I = 2'b11;
            cyc();
        end
        chk("fair_wrap", grant, 2'b01);
        chk("fair_reg", slave_reg, 32'hA5A5_0002);
        m_CYC_I = 2'b00; m_STB_I = 2'b00;
        cyc();

        // 3 isolation
        m_CYC_I = 2'b10; m_STB_I = 2'b10; m_WE_I = 2'b00;
        cyc();
        chk("iso_grant", grant, 2'b10);
        m_CYC_I = 2'b11; m_STB_I = 2'b11;
        s_DAT_I = 32'hDEAD_BEEF; s_ACK_I = 1'b1;
        #1;
        chk("iso_ack", m_ACK_O, 2'b10);
        chk("iso_rdat", m_DAT_O, 32'hDEAD_BEEF);
        chk("iso_sadr", s_ADR_O, 32'h0000_2000);
        cyc();
        s_ACK_I = 1'b0; m_STB_I = 2'b01;
        repeat (2) cyc();
        chk("iso_hold", grant, 2'b10);
        m_CYC_I = 2'b01;
        cyc();
        chk("iso_idle", grant, 2'b00);
        cyc();
        chk("iso_m0", grant, 2'b01);
        chk("iso_m0adr", s_ADR_O, 32'h0000_1000);
        m_CYC_I = 2'b00; m_STB_I = 2'b00;
        cyc();

        // 4 lock
        m_CYC_I = 2'b01; m_STB_I = 2'b01; m_WE_I = 2'b01; m_LOCK_I = 2'b01;
        cyc();
        chk("lk_grant", grant, 2'b01);
        s_ACK_I = 1'b1;
        cyc();
        s_ACK_I = 1'b0; m_CYC_I = 2'b10; m_STB_I = 2'b10;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("lk_hold", grant, 2'b01);
            chk("lk_scyc", s_CYC_O, 1'b0);
            chk("lk_slock", s_LOCK_O, 1'b1);
        end
        m_LOCK_I = 2'b00;
        cyc();
        chk("lk_idle", grant, 2'b00);
        cyc();
        chk("lk_m1", grant, 2'b10);
        m_CYC_I = 2'b00; m_STB_I = 2'b00;
        cyc();

        // 5 watchdog
        m_CYC_I = 2'b01; m_STB_I = 2'b01;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            chk("wd_err", m_ERR_O, (k == 8) ? 2'b01 : 2'b00);
            chk("wd_sstb", s_STB_O, (k == 8) ? 1'b0 : 1'b1);
            cyc();
        end
        chk("wd_err_after", m_ERR_O, 2'b00);
        chk("wd_sstb_after", s_STB_O, 1'b1);
        m_CYC_I = 2'b00; m_STB_I = 2'b00;
        cyc();

        // 6 race and mid-burst reset
        m_CYC_I = 2'b01; m_STB_I = 2'b01;
        cyc();
        repeat (7) cyc();
        s_ACK_I = 1'b1;
        #1;
        chk("race_ack", m_ACK_O, 2'b01);
        chk("race_err", m_ERR_O, 2'b00);
        chk("race_sstb", s_STB_O, 1'b1);
        cyc();
        chk("burst_grant", grant, 2'b01);
        #2;
        p_resetn = 1'b0;
        #1;
        chk("ar_grant", grant, 2'b00);
        chk("ar_scyc", s_CYC_O, 1'b0);
        chk("ar_sstb", s_STB_O, 1'b0);
        chk("ar_ack", m_ACK_O, 2'b00);
        s_ACK_I = 1'b0; m_CYC_I = 2'b00; m_STB_I = 2'b00;
        p_resetn = 1'b1;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
